// File: rtl/acc_alu_unit.sv
// acc_alu_unit: accumulator/B/TMP datapath with multi-function ALU, flags, XCHG sequencer and output latch
module acc_alu_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] operand,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] acc_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              carry,
    output logic              zero
);
    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_XCHG = 4'h3, OP_MOVA = 4'h4,
                           OP_MOVB = 4'h5, OP_AND = 4'h6, OP_OR = 4'h7, OP_XOR = 4'h8,
                           OP_ADC = 4'h9, OP_SBB = 4'hA, OP_INC = 4'hB, OP_DEC = 4'hC,
                           OP_CMP = 4'hD, OP_OUT = 4'hE, OP_RSV = 4'hF;

    typedef enum logic [1:0] {IDLE, EXEC, XCH1, XCH2} state_t;

    state_t              state, state_nx;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   opd_q, tmp;
    logic [DATA_W:0]     ax, bx, cx, one, res;
    logic                wr_a, wr_f;

    // Operands extended by one bit so bit DATA_W carries the carry/borrow
    assign ax       = {1'b0, acc_out};
    assign bx       = {1'b0, b_out};
    assign cx       = {{DATA_W{1'b0}}, carry};
    assign one      = {{DATA_W{1'b0}}, 1'b1};
    assign op_ready = (state == IDLE);

    always_comb begin
        res  = '0;
        wr_a = 1'b0;
        wr_f = 1'b0;
        case (op_q)
            OP_ADD:  begin res = ax + bx;            wr_a = 1'b1; wr_f = 1'b1; end
            OP_SUB:  begin res = ax - bx;            wr_a = 1'b1; wr_f = 1'b1; end
            OP_AND:  begin res = ax & bx;            wr_a = 1'b1; wr_f = 1'b1; end
            OP_OR:   begin res = ax | bx;            wr_a = 1'b1; wr_f = 1'b1; end
            OP_XOR:  begin res = ax ^ bx;            wr_a = 1'b1; wr_f = 1'b1; end
            OP_ADC:  begin res = ax + bx + cx;       wr_a = 1'b1; wr_f = 1'b1; end
            OP_SBB:  begin res = ax - bx - cx;       wr_a = 1'b1; wr_f = 1'b1; end
            OP_INC:  begin res = ax + one;           wr_a = 1'b1; wr_f = 1'b1; end
            OP_DEC:  begin res = ax - one;           wr_a = 1'b1; wr_f = 1'b1; end
            OP_CMP:  begin res = ax - bx;                         wr_f = 1'b1; end
            OP_MOVA: begin res = {1'b0, opd_q};      wr_a = 1'b1;              end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (op_valid) state_nx = (opcode == OP_XCHG) ? XCH1 : EXEC;
            EXEC: state_nx = IDLE;
            XCH1: state_nx = XCH2;
            XCH2: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= '0;
            opd_q     <= '0;
            acc_out   <= '0;
            b_out     <= '0;
            tmp       <= '0;
            out_data  <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            done      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            if (op_valid && op_ready) begin
                op_q  <= opcode;
                opd_q <= operand;
            end
            if (state == EXEC) begin
                done <= (op_q != OP_RSV);
                err  <= (op_q == OP_RSV);
                if (wr_a) acc_out <= res[DATA_W-1:0];
                if (wr_f) begin
                    carry <= res[DATA_W];
                    zero  <= (res[DATA_W-1:0] == '0);
                end
                if (op_q == OP_MOVB) b_out <= acc_out;
                if (op_q == OP_OUT) begin
                    out_data  <= acc_out;
                    out_valid <= 1'b1;
                end
            end
            if (state == XCH1) begin
                tmp     <= acc_out;
                acc_out <= b_out;
            end
            if (state == XCH2) begin
                b_out <= tmp;
                done  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_acc_alu_unit.sv
// tb_acc_alu_unit: randomized and directed checks of acc_alu_unit against an arithmetic reference model
module tb_acc_alu_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] opcode = '0;
    logic [7:0] operand = '0;
    logic       done, err, out_valid, carry, zero;
    logic [7:0] acc_out, b_out, out_data;

    logic       v4 = 1'b0, r4, dn4, er4, ov4, c4, z4;
    logic [3:0] oc4 = '0, od4 = '0, a4, b4, o4;

    int n_cmp = 0;
    int n_err = 0;

    int m_a, m_b, m_out;
    bit m_c, m_z;

    always #5 clk = ~clk;

    acc_alu_unit #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .operand(operand), .done(done), .err(err),
        .acc_out(acc_out), .b_out(b_out), .out_data(out_data), .out_valid(out_valid),
        .carry(carry), .zero(zero)
    );

    acc_alu_unit #(.DATA_W(4)) dut4 (
        .clk(clk), .reset(reset), .op_valid(v4), .op_ready(r4),
        .opcode(oc4), .operand(od4), .done(dn4), .err(er4),
        .acc_out(a4), .b_out(b4), .out_data(o4), .out_valid(ov4),
        .carry(c4), .zero(z4)
    );

    wire logic [25:0] dv = {acc_out, b_out, carry, zero, out_data};

    function automatic logic [25:0] exp_vec();
        return {8'(m_a), 8'(m_b), m_c, m_z, 8'(m_out)};
    endfunction

    function automatic void model_reset();
        m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_z = 0;
    endfunction

    // Reference semantics in plain integer arithmetic, 8-bit unsigned
    function automatic void model(input logic [3:0] op, input int d);
        int t;
        case (op)
            4'h1: begin t = m_a + m_b;       m_c = t > 255;             m_a = t % 256; m_z = m_a == 0; end
            4'h2: begin m_c = m_a < m_b;     m_a = (m_a - m_b + 256) % 256;            m_z = m_a == 0; end
            4'h3: begin t = m_a; m_a = m_b; m_b = t; end
            4'h4: m_a = d;
            4'h5: m_b = m_a;
            4'h6: begin m_a = m_a & m_b; m_c = 0; m_z = m_a == 0; end
            4'h7: begin m_a = m_a | m_b; m_c = 0; m_z = m_a == 0; end
            4'h8: begin m_a = m_a ^ m_b; m_c = 0; m_z = m_a == 0; end
            4'h9: begin t = m_a + m_b + int'(m_c); m_c = t > 255; m_a = t % 256; m_z = m_a == 0; end
            4'hA: begin t = m_a - m_b - int'(m_c); m_c = t < 0; m_a = (t + 512) % 256; m_z = m_a == 0; end
            4'hB: begin t = m_a + 1; m_c = t > 255; m_a = t % 256; m_z = m_a == 0; end
            4'hC: begin m_c = m_a == 0; m_a = (m_a + 255) % 256; m_z = m_a == 0; end
            4'hD: begin m_c = m_a < m_b; m_z = m_a == m_b; end
            4'hE: m_out = m_a;
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [7:0] d, output int lat,
                         output logic d_s, output logic e_s, output logic ov_s);
        @(negedge clk);
        op_valid = 1'b1; opcode = op; operand = d;
        @(posedge clk); #1;
        op_valid = 1'b0; opcode = 4'($urandom); operand = 8'($urandom);
        lat = 0; d_s = 0; e_s = 0; ov_s = 0;
        for (int i = 2; i <= 8 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (done || err) begin lat = i; d_s = done; e_s = err; ov_s = out_valid; end
        end
        model(op, int'(d));
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        n_cmp++;
        if (dv !== exp_vec()) begin n_err++; $display("FAIL reset_regs: got %h want %h", dv, exp_vec()); end
        n_cmp++;
        if ({op_ready, done, err, out_valid} !== 4'b1000) begin
            n_err++; $display("FAIL reset_ctl: got %b want 1000", {op_ready, done, err, out_valid});
        end
        reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [11:0] seq [] = '{12'h40F, 12'h500, 12'h4F0, 12'h100, 12'hB00,
                                12'h40A, 12'h500, 12'h405, 12'h200, 12'h404, 12'h500, 12'h4FB, 12'h900,
                                12'h4AA, 12'hE00, 12'hF00, 12'h43C, 12'h500, 12'h4C3, 12'hD00,
                                12'h600, 12'h700, 12'h800, 12'hA00, 12'hC00, 12'h000};
        int lat;
        logic d_s, e_s, ov_s;
        foreach (seq[i]) begin
            issue(seq[i][11:8], seq[i][7:0], lat, d_s, e_s, ov_s);
            n_cmp++;
            if (lat !== 2 || {d_s, e_s, ov_s} !== {seq[i][11:8] != 4'hF, seq[i][11:8] == 4'hF, seq[i][11:8] == 4'hE}) begin
                n_err++; $display("FAIL directed_timing[%0d] op %h: lat %0d pulses %b", i, seq[i][11:8], lat, {d_s, e_s, ov_s});
            end
            n_cmp++;
            if (dv !== exp_vec()) begin n_err++; $display("FAIL directed_regs[%0d] op %h: got %h want %h", i, seq[i][11:8], dv, exp_vec()); end
        end
    endtask

    task automatic test_xchg();
        int lat;
        logic d_s, e_s, ov_s;
        logic [5:0] obs;
        issue(4'h4, 8'h34, lat, d_s, e_s, ov_s);
        issue(4'h5, 8'h00, lat, d_s, e_s, ov_s);
        issue(4'h4, 8'h12, lat, d_s, e_s, ov_s);
        @(negedge clk);
        op_valid = 1'b1; opcode = 4'h3; operand = 8'($urandom);
        @(posedge clk); #1;
        op_valid = 1'b0; opcode = 4'h4;
        obs[5:4] = {op_ready, done};
        @(posedge clk); #1;
        obs[3:2] = {op_ready, done};
        @(posedge clk); #1;
        obs[1:0] = {op_ready, done};
        model(4'h3, 0);
        n_cmp++;
        if (obs !== 6'b000011) begin n_err++; $display("FAIL xchg_timing: ready/done got %b want 000011", obs); end
        n_cmp++;
        if ({acc_out, b_out} !== 16'h3412) begin n_err++; $display("FAIL xchg_swap: got %h want 3412", {acc_out, b_out}); end
        n_cmp++;
        if (dv !== exp_vec()) begin n_err++; $display("FAIL xchg_regs: got %h want %h", dv, exp_vec()); end
    endtask

    task automatic test_reset_mid_xchg();
        int lat;
        logic d_s, e_s, ov_s;
        logic seen = 1'b0;
        issue(4'h4, 8'h77, lat, d_s, e_s, ov_s);
        @(negedge clk);
        op_valid = 1'b1; opcode = 4'h3;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({dv, op_ready, done} !== {exp_vec(), 2'b10}) begin
            n_err++; $display("FAIL reset_mid_xchg: regs %h ready %b done %b", dv, op_ready, done);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin @(negedge clk); reset = 1'b1; end
            @(posedge clk); #1;
            seen |= done | err;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL reset_no_done: got done pulse, want none"); end
        issue(4'h4, 8'h55, lat, d_s, e_s, ov_s);
        n_cmp++;
        if (lat !== 2 || d_s !== 1'b1 || dv !== exp_vec()) begin
            n_err++; $display("FAIL post_reset_mov: lat %0d done %b regs %h want %h", lat, d_s, dv, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [14] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        logic [3:0] op;
        logic [7:0] d;
        @(negedge clk);
        op_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++;
            if (op_ready !== 1'b1 || (i > 0 && (done !== 1'b1 || dv !== exp_vec()))) begin
                n_err++; $display("FAIL b2b_done[%0d]: ready %b done %b regs %h want %h", i, op_ready, done, dv, exp_vec());
            end
            op = ops[$urandom_range(0, 13)];
            d = 8'($urandom);
            opcode = op; operand = d;
            model(op, int'(d));
            @(negedge clk);
            n_cmp++;
            if ({op_ready, done} !== 2'b00) begin n_err++; $display("FAIL b2b_busy[%0d]: ready/done %b want 00", i, {op_ready, done}); end
            opcode = 4'($urandom); operand = 8'($urandom);
            if (i == 11) op_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || dv !== exp_vec()) begin n_err++; $display("FAIL b2b_last: done %b regs %h want %h", done, dv, exp_vec()); end
    endtask

    task automatic test_random();
        int lat;
        logic d_s, e_s, ov_s;
        logic [3:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom);
            issue(op, 8'($urandom), lat, d_s, e_s, ov_s);
            n_cmp++;
            if (lat !== (op == 4'h3 ? 3 : 2) || {d_s, e_s, ov_s} !== {op != 4'hF, op == 4'hF, op == 4'hE}) begin
                n_err++; $display("FAIL random_timing[%0d] op %h: lat %0d pulses %b", i, op, lat, {d_s, e_s, ov_s});
            end
            n_cmp++;
            if (dv !== exp_vec()) begin n_err++; $display("FAIL random_regs[%0d] op %h: got %h want %h", i, op, dv, exp_vec()); end
        end
    endtask

    task automatic op4(input logic [3:0] op, input logic [3:0] d);
        @(negedge clk);
        v4 = 1'b1; oc4 = op; od4 = d;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_w4();
        op4(4'h4, 4'h1); op4(4'h5, 4'h0); op4(4'h4, 4'hF); op4(4'h1, 4'h0);
        n_cmp++;
        if ({a4, c4, z4, dn4} !== {4'h0, 3'b111}) begin
            n_err++; $display("FAIL w4_add: acc/c/z/done got %h %b%b%b want 0 111", a4, c4, z4, dn4);
        end
        op4(4'h4, 4'h3); op4(4'h5, 4'h0); op4(4'hD, 4'h0);
        n_cmp++;
        if ({a4, c4, z4, dn4} !== {4'h3, 3'b011}) begin
            n_err++; $display("FAIL w4_cmp: acc/c/z/done got %h %b%b%b want 3 011", a4, c4, z4, dn4);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_xchg();
        test_reset_mid_xchg();
        test_back_to_back();
        test_random();
        test_w4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/acc_alu_unit.md
Name: acc_alu_unit

Overview:
- Parametrised accumulator/B/TMP datapath with a multi-function ALU and flags.
- Executes one decoded operation per handshake, issued by the control sequencer.
- Replaces the fixed 4-bit A/TMP/B/ALU chain with:
  - configurable data width
  - a valid/ready issue handshake
  - carry/zero flags
  - a multi-cycle XCHG sequencer
  - an output latch

Parameters:
- DATA_W, 8, width of A, B, TMP, OUT and ALU datapath (min 2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_valid  input  1  sequencer presents an operation.
- op_ready  output  1  unit can accept; high only in IDLE (combinational from state).
- opcode  input  4  operation code, sampled at accept.
- operand  input  DATA_W  immediate/memory data, sampled at accept.
- done  output  1  one-cycle pulse: operation complete, results visible.
- err  output  1  one-cycle pulse: reserved opcode rejected.
- acc_out  output  DATA_W  A register.
- b_out  output  DATA_W  B register.
- out_data  output  DATA_W  output latch.
- out_valid  output  1  one-cycle pulse when out_data updated.
- carry  output  1  carry/borrow flag.
- zero  output  1  zero flag.

Behaviour:
- Reset (async, active-low):
  - A, B, TMP, out_data cleared to 0; carry=0, zero=0; done=err=out_valid=0.
  - FSM returns to IDLE, so op_ready=1 while in reset.
  - Any in-flight operation, including mid-XCHG, is aborted with no done.
- Accept occurs on a rising edge with op_valid && op_ready; opcode and operand are registered.
- FSM states: IDLE, EXEC, XCH1, XCH2.
  - IDLE + accept, non-XCHG opcode -> EXEC.
  - IDLE + accept, XCHG opcode -> XCH1.
  - EXEC -> IDLE.
  - XCH1 (TMP<=A, A<=B) -> XCH2 (B<=TMP) -> IDLE.
- Completion:
  - Writes happen on the edge leaving EXEC/XCH2.
  - done is registered: high the cycle after the final write, coincident with op_ready=1.
  - A new op may be accepted that same cycle (back-to-back).
- Latency from accept edge to done-high: 2 edges for single ops, 3 edges for XCHG.
- Opcodes (a=A, b=B, c=carry):
  - 0000 NOP (EXEC, done, nothing changes)
  - 0001 ADD a=a+b
  - 0010 SUB a=a-b
  - 0011 XCHG
  - 0100 MOV A,operand
  - 0101 MOV B,A
  - 0110 AND
  - 0111 OR
  - 1000 XOR
  - 1001 ADC a=a+b+c
  - 1010 SBB a=a-b-c
  - 1011 INC a
  - 1100 DEC a
  - 1101 CMP (flags of a-b, A unchanged)
  - 1110 OUT (out_data<=A, out_valid pulses with done)
  - 1111 reserved: accepted, goes to EXEC, no register/flag change, err pulses instead of done.
- Arithmetic rules:
  - All arithmetic is unsigned, modulo 2^DATA_W; computed at DATA_W+1 bits.
  - ADD/ADC/INC: carry = bit DATA_W of sum.
  - SUB/SBB/DEC/CMP: carry = borrow (1 when minuend < subtrahend + borrow-in).
  - zero = (result[DATA_W-1:0]==0).
  - AND/OR/XOR: carry<=0, zero updated.
  - MOV/XCHG/OUT/NOP: flags unchanged.
  - ADC/SBB use the carry value as of the accept edge.
- Holding inputs:
  - op_valid held while busy is ignored until op_ready.
  - opcode/operand changes while busy have no effect.

Test Plan:
- MOV A,0x0F; MOV B,A; MOV A,0xF0; ADD -> acc_out=0xFF, carry=0, zero=0; INC -> acc_out=0x00, carry=1, zero=1; each done exactly 2 edges after its accept.
- A=0x05, B=0x0A; SUB -> acc_out=0xFB, carry=1; ADC with B=0x04 -> acc_out=0x00, carry=1, zero=1.
- A=0x12, B=0x34; XCHG -> op_ready low 2 cycles, done 3 edges after accept, acc_out=0x34, b_out=0x12, flags unchanged.
- XCHG accepted, reset asserted during XCH2 -> all registers 0, no done pulse, op_ready=1; after release MOV A,0x55 completes normally.
- A=0xAA; OUT -> out_data=0xAA, out_valid and done high the same single cycle; then opcode 1111 -> err pulse, no done, A/flags unchanged; op_valid held high continuously -> back-to-back accepts every 2 cycles.
- DATA_W=4 instance: A=0xF, B=0x1, ADD -> acc_out=0x0, carry=1, zero=1; CMP with A=0x3, B=0x3 -> zero=1, carry=0, acc_out stays 0x3.
